// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, sitting beside dmem on the core data bus.
// Status and divisor are read back combinationally; tx and irq are registered.
module mmio_uart_tx #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DIV_RESET = 16,
  parameter logic [31:0] BASE      = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        hit,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     div_q, div_d;
  logic [15:0]     divl_q, divl_d;
  logic [15:0]     btc_q, btc_d;
  logic [2:0]      bidx_q, bidx_d;
  logic [7:0]      sh_q, sh_d;
  logic            tx_q, tx_d;
  logic            irq_q;

  logic wr_data, wr_stat, wr_div;
  logic full, empty, busy, push, pop, bit_end;
  logic [3:0]  cnt_disp;
  logic [31:0] count_ext;
  logic        unused_bits;

  assign unused_bits = ^{a[1:0], wd[31:16]};

  assign hit     = (a[31:4] == BASE[31:4]);
  assign wr_data = we && hit && (a[3:2] == 2'd0);
  assign wr_stat = we && hit && (a[3:2] == 2'd1);
  assign wr_div  = we && hit && (a[3:2] == 2'd2);

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign busy    = (state_q != StIdle);
  assign pop     = (state_q == StIdle) && !empty;
  // A full FIFO still accepts a push when the transmitter drains a slot on the same edge.
  assign push    = wr_data && (!full || pop);
  assign bit_end = (btc_q == divl_q - 16'd1);

  assign count_ext = 32'(count_q);
  assign cnt_disp  = (count_ext > 32'd15) ? 4'hf : count_ext[3:0];

  always_comb begin
    rd = '0;
    if (hit) begin
      case (a[3:2])
        2'd1:    rd = {24'd0, cnt_disp, busy, ovf_q, empty, full};
        2'd2:    rd = {16'd0, div_q};
        default: rd = '0;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    ovf_d = ovf_q;
    if (wr_data && !push)      ovf_d = 1'b1;
    if (wr_stat && wd[2])      ovf_d = 1'b0;

    div_d = div_q;
    if (wr_div) div_d = (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
  end

  always_comb begin
    state_d = state_q;
    btc_d   = btc_q;
    bidx_d  = bidx_q;
    sh_d    = sh_q;
    divl_d  = divl_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          sh_d    = mem_q[rptr_q];
          divl_d  = div_q;
          btc_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          btc_d   = '0;
          bidx_d  = '0;
          state_d = StData;
        end else begin
          btc_d = btc_q + 16'd1;
        end
      end
      StData: begin
        if (bit_end) begin
          btc_d = '0;
          sh_d  = sh_q >> 1;
          if (bidx_q == 3'd7) state_d = StStop;
          else                bidx_d  = bidx_q + 3'd1;
        end else begin
          btc_d = btc_q + 16'd1;
        end
      end
      StStop: begin
        if (bit_end) begin
          btc_d   = '0;
          state_d = StIdle;
        end else begin
          btc_d = btc_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // tx is registered from the next state so the line follows the FSM without a cycle of lag.
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = sh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wd[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      div_q   <= 16'(DIV_RESET);
      divl_q  <= 16'(DIV_RESET);
      btc_q   <= '0;
      bidx_q  <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
      div_q   <= div_d;
      divl_q  <= divl_d;
      btc_q   <= btc_d;
      bidx_q  <= bidx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      irq_q   <= empty && (state_q == StIdle);
    end
  end

  assign tx  = tx_q;
  assign irq = irq_q;

endmodule
